// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared encodings for the streaming expression recogniser
package expr_pkg;

  typedef enum logic [1:0] {
    S_EXPECT = 2'd0,
    S_NUM    = 2'd1,
    S_CLOSE  = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_DIGIT = 3'd0,
    C_OP    = 3'd1,
    C_LP    = 3'd2,
    C_RP    = 3'd3,
    C_BAD   = 3'd4
  } cls_t;

  localparam logic [7:0] A_0     = 8'h30;
  localparam logic [7:0] A_9     = 8'h39;
  localparam logic [7:0] A_PLUS  = 8'h2B;
  localparam logic [7:0] A_MINUS = 8'h2D;
  localparam logic [7:0] A_STAR  = 8'h2A;
  localparam logic [7:0] A_SLASH = 8'h2F;
  localparam logic [7:0] A_LP    = 8'h28;
  localparam logic [7:0] A_RP    = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - maps an ASCII character to its lexical class
module expr_char_class
  import expr_pkg::*;
#(
  parameter logic [3:0] OP_MASK = 4'b0101
) (
  input  logic [7:0] in,
  output cls_t       cls
);

  // Disabled operators fall through to C_BAD like any other unknown byte.
  always_comb begin
    cls = C_BAD;
    if (in >= A_0 && in <= A_9)              cls = C_DIGIT;
    else if (in == A_LP)                     cls = C_LP;
    else if (in == A_RP)                     cls = C_RP;
    else if (in == A_PLUS  && OP_MASK[0])    cls = C_OP;
    else if (in == A_MINUS && OP_MASK[1])    cls = C_OP;
    else if (in == A_STAR  && OP_MASK[2])    cls = C_OP;
    else if (in == A_SLASH && OP_MASK[3])    cls = C_OP;
  end

endmodule

// File: rtl/expr_checker.sv
// rtl/expr_checker.sv - streaming recogniser for parenthesised arithmetic expressions
module expr_checker
  import expr_pkg::*;
#(
  parameter int         MAX_DIGITS = 4,
  parameter int         DEPTH_W    = 3,
  parameter logic [3:0] OP_MASK    = 4'b0101
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [7:0]         op_cnt
);

  localparam logic [3:0]         MAX_DIG   = 4'(MAX_DIGITS);
  localparam logic [DEPTH_W-1:0] MAX_DEPTH = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  cls_t               cls;
  state_t             state_q, state_d;
  logic [3:0]         dcnt_q, dcnt_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [7:0]         op_q, op_d;

  expr_char_class #(.OP_MASK(OP_MASK)) u_class (
    .in  (in),
    .cls (cls)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_EXPECT;
      dcnt_q  <= 4'd0;
      depth_q <= '0;
      op_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      depth_q <= depth_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    depth_d = depth_q;
    op_d    = op_q;
    if (in_valid) begin
      case (state_q)
        S_EXPECT: begin
          if (cls == C_DIGIT) begin
            state_d = S_NUM;
            dcnt_d  = 4'd1;
          end else if (cls == C_LP && depth_q != MAX_DEPTH) begin
            depth_d = depth_q + DEPTH_ONE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM, S_CLOSE: begin
          // S_NUM and S_CLOSE share operator and ')' handling; only S_NUM extends an operand.
          if (cls == C_DIGIT && state_q == S_NUM) begin
            if (dcnt_q == MAX_DIG) state_d = S_ERR;
            else                   dcnt_d  = dcnt_q + 4'd1;
          end else if (cls == C_OP) begin
            state_d = S_EXPECT;
            if (op_q != 8'hFF) op_d = op_q + 8'd1;
          end else if (cls == C_RP && depth_q != '0) begin
            state_d = S_CLOSE;
            depth_d = depth_q - DEPTH_ONE;
          end else begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_ERR;
      endcase
    end
  end

  assign out    = (state_q == S_NUM || state_q == S_CLOSE) && depth_q == '0;
  assign err    = (state_q == S_ERR);
  assign depth  = depth_q;
  assign op_cnt = op_q;

endmodule

// File: tb/tb_expr_checker.sv
// tb/tb_expr_checker.sv - scoreboard bench for expr_checker against a token-grammar model
module tb_expr_checker;

  localparam int MAXD  = 4;
  localparam int MAXDP = 7;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;
  logic       out, err;
  logic [2:0] depth;
  logic [7:0] op_cnt;

  expr_checker #(.MAX_DIGITS(4), .DEPTH_W(3), .OP_MASK(4'b0101)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out), .err(err), .depth(depth), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       out;
    logic       err;
    logic [2:0] depth;
    logic [7:0] op;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: what kind of token the last accepted character was.
  // 's' = start of operand expected, 'd' = inside number, ')' = after close.
  bit  m_err;
  int  m_depth, m_ops, m_cur;
  byte m_prev;

  task automatic model_reset();
    m_err = 0; m_depth = 0; m_ops = 0; m_cur = 0; m_prev = "s";
  endtask

  task automatic model_char(input byte ch);
    bit is_dig, is_op;
    if (m_err) return;
    is_dig = (ch >= "0" && ch <= "9");
    is_op  = (ch == "+" || ch == "*");
    if (is_dig) begin
      if (m_prev == "s") begin m_cur = 1; m_prev = "d"; end
      else if (m_prev == "d" && m_cur < MAXD) m_cur++;
      else m_err = 1;
    end else if (is_op) begin
      if (m_prev == "d" || m_prev == ")") begin
        m_ops = (m_ops < 255) ? m_ops + 1 : 255;
        m_prev = "s";
      end else m_err = 1;
    end else if (ch == "(") begin
      if (m_prev == "s" && m_depth < MAXDP) m_depth++;
      else m_err = 1;
    end else if (ch == ")") begin
      if ((m_prev == "d" || m_prev == ")") && m_depth > 0) begin
        m_depth--; m_prev = ")";
      end else m_err = 1;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic step(input bit c, input bit v, input byte ch);
    exp_t e;
    @(negedge clk);
    clr = c; in_valid = v; in = ch;
    if (c) model_reset();
    else if (v) model_char(ch);
    e.due   = cyc + 1;
    e.err   = m_err;
    e.out   = !m_err && m_depth == 0 && (m_prev == "d" || m_prev == ")");
    e.depth = 3'(m_depth);
    e.op    = 8'(m_ops);
    sb.push_back(e);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(0, 1, s[i]);
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (out !== mon_e.out || err !== mon_e.err || depth !== mon_e.depth || op_cnt !== mon_e.op) begin
        n_bad++;
        $display("FAIL sb cyc=%0d: got out=%b err=%b depth=%0d op=%0d expected out=%b err=%b depth=%0d op=%0d",
                 cyc, out, err, depth, op_cnt, mon_e.out, mon_e.err, mon_e.depth, mon_e.op);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  string alpha = "0123456789012345+-*/()(()) x";
  int    r;

  initial begin
    model_reset();
    step(1, 0, 8'h00);
    send_str("12+345");
    step(1, 0, 8'h00);
    send_str("(1+2)*3");
    step(1, 0, 8'h00);
    send_str("12345+1");
    step(1, 0, 8'h00);
    send_str("3-4");
    step(1, 0, 8'h00);
    send_str("1)");
    step(1, 0, 8'h00);
    send_str("((((((((");
    step(1, 0, 8'h00);
    send_str("9");
    repeat (3) step(0, 0, "x");
    step(1, 1, "5");
    send_str("1");
    repeat (300) send_str("+1");
    @(negedge clk);
    check_val("sat_op_cnt", op_cnt, 255);
    check_val("sat_out", out, 1);
    check_val("sat_err", err, 0);

    step(1, 0, 8'h00);
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 4)       step(1, $urandom_range(0, 1), alpha[$urandom_range(0, alpha.len() - 1)]);
      else if (r < 14) step(0, 0, alpha[$urandom_range(0, alpha.len() - 1)]);
      else             step(0, 1, alpha[$urandom_range(0, alpha.len() - 1)]);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
